// File: rtl/exmem_skid_stage.sv
// EX->MEM pipeline stage with optional two-entry skid buffer and stall counter.
// Latency: 1 cycle from accept to out_valid/out_data; flush empties the stage in 1 cycle.
// Backpressure: with EXMEM_SKID_STAGE_SKID_EN, in_ready is registered (= next state not full);
//               without it, in_ready = !out_valid | out_ready (combinational pass-through).
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   flush                drop every held entry (mispredict / trap)
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload (always the main register)
//   occupancy            entries held (0..2)
//   stat_clr/stall_cnt   saturating count of cycles out_valid & !out_ready, clearable
// Build option: define EXMEM_SKID_STAGE_SKID_EN for the two-entry skid version.
module exmem_skid_stage #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             in_fire, out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

`ifdef EXMEM_SKID_STAGE_SKID_EN
    localparam logic [1:0] ST_TWO = 2'd2;

    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;

    // Registered ready breaks the out_ready -> in_ready timing path; the skid
    // register absorbs the one entry that can arrive while ready is stale.
    assign in_ready = in_ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (!in_fire && out_fire) begin
                        state_d = ST_EMPTY;
                    end else if (in_fire && out_fire) begin
                        main_d  = in_data;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end
`else
    // Single register: a new entry may enter only as the held one leaves.
    assign in_ready = !out_valid | out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire) begin
                        main_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end
`endif

    // Stall statistics: clear beats increment; flush is deliberately ignored.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Testbench for exmem_skid_stage: queue-based reference model checked every
// negative edge, plus directed sequences with literal expectations.
// Works for both builds (EXMEM_SKID_STAGE_SKID_EN defined or not).
module tb_exmem_skid_stage;

    localparam int W  = 128;
    localparam int CW = 4;
`ifdef EXMEM_SKID_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          CLK;
    logic          nRST;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic          stat_clr;
    logic [CW-1:0] stall_cnt;

    exmem_skid_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stat_clr  (stat_clr),
        .stall_cnt (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [127:0] mq[$];
    int           mcnt;

    function automatic bit m_in_ready();
        if (SKID) return (mq.size() < 2);
        return (mq.size() == 0) || (out_ready == 1'b1);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mq.delete();
            mcnt = 0;
        end else begin
            bit inf;
            bit outf;
            inf  = (in_valid == 1'b1) && m_in_ready();
            outf = (mq.size() > 0) && (out_ready == 1'b1);
            if (stat_clr) mcnt = 0;
            else if ((mq.size() > 0) && !out_ready && (mcnt < (1 << CW) - 1)) mcnt++;
            if (flush) begin
                mq.delete();
            end else begin
                if (outf) void'(mq.pop_front());
                if (inf)  mq.push_back(in_data);
            end
        end
    end

    always @(negedge CLK) begin
        if (nRST) begin
            check("out_valid", 128'(out_valid), 128'(mq.size() > 0));
            check("occupancy", 128'(occupancy), 128'(mq.size()));
            check("in_ready",  128'(in_ready),  128'(m_in_ready()));
            check("stall_cnt", 128'(stall_cnt), 128'(mcnt));
            if (mq.size() > 0) check("out_data", out_data, mq[0]);
        end
    end

    // Stream monitor: order and occupancy bound during back-to-back traffic.
    bit mon_en = 1'b0;
    int exp_next = 0;
    always @(negedge CLK) begin
        if (mon_en) begin
            check("stream_occ_lt2", 128'(occupancy < 2'd2), 128'(1));
            if (out_valid && out_ready) begin
                check("stream_order", out_data, 128'(exp_next));
                exp_next++;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; stat_clr = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready",  128'(in_ready),  128'(1));
        check("rst_occupancy", 128'(occupancy), 128'(0));
        check("rst_stall_cnt", 128'(stall_cnt), 128'(0));
        check("rst_out_data",  out_data,        128'(0));
        nRST = 1'b1;

        // Single entry with 1-cycle latency
        in_valid = 1'b1; in_data = 128'hA5; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("a5_out_valid", 128'(out_valid), 128'(1));
        check("a5_out_data",  out_data,        128'hA5);
        check("a5_occ",       128'(occupancy), 128'(1));
        step();
        check("a5_drain_occ", 128'(occupancy), 128'(0));
        check("a5_drain_vld", 128'(out_valid), 128'(0));

        // Fill under backpressure, then release
        out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h11;
        step();
        in_data = 128'h22;
        step();
        in_valid = 1'b0;
        check("fill_out_data", out_data, 128'h11);
        if (SKID) begin
            check("fill_occ2",     128'(occupancy), 128'(2));
            check("fill_in_ready", 128'(in_ready),  128'(0));
            out_ready = 1'b1;
            #1;
            check("ready_no_comb_path", 128'(in_ready), 128'(0));
            step();
            check("rel_out_data", out_data,        128'h22);
            check("rel_in_ready", 128'(in_ready),  128'(1));
            step();
            check("rel_occ0",     128'(occupancy), 128'(0));
        end else begin
            check("fill_occ1", 128'(occupancy), 128'(1));
            out_ready = 1'b1;
            step();
            check("rel_occ0", 128'(occupancy), 128'(0));
        end

        // Back-to-back stream 0..99
        mon_en = 1'b1; exp_next = 0;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 128'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        mon_en = 1'b0;
        check("stream_count", 128'(exp_next), 128'(100));

        // Flush with a simultaneous input
        out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h44;
        step();
        in_data = 128'h55;
        step();
        check("pre_flush_occ", 128'(occupancy), SKID ? 128'(2) : 128'(1));
        flush = 1'b1; in_data = 128'h33;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_occ",       128'(occupancy), 128'(0));
        check("flush_in_ready",  128'(in_ready),  128'(1));
        out_ready = 1'b1;
        step();
        check("flush_no_33", 128'(out_valid), 128'(0));

        // Stall counter saturation, clear, flush independence
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("clr_stall", 128'(stall_cnt), 128'(0));
        out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h66;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        check("stall_sat", 128'(stall_cnt), 128'(15));
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("stall_clr", 128'(stall_cnt), 128'(0));
        step();
        step();
        check("stall_two", 128'(stall_cnt), 128'(2));
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("stall_flush_keep", 128'(stall_cnt), 128'(3));

        // Asynchronous reset mid-cycle with the stage full
        out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h77;
        step();
        in_data = 128'h88;
        step();
        in_valid = 1'b0;
        check("prerst_occ", 128'(occupancy), SKID ? 128'(2) : 128'(1));
        #2;
        nRST = 1'b0;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'(0));
        check("arst_occ",       128'(occupancy), 128'(0));
        check("arst_in_ready",  128'(in_ready),  128'(1));
        check("arst_stall",     128'(stall_cnt), 128'(0));
        check("arst_out_data",  out_data,        128'(0));
        @(negedge CLK);
        #1;
        nRST = 1'b1;
        in_valid = 1'b1; in_data = 128'h99; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_rst_data", out_data,        128'h99);
        check("post_rst_occ",  128'(occupancy), 128'(1));
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exmem_skid_stage.md
EXMEM_SKID_STAGE -- requirements
Module: exmem_skid_stage

Interface
REQ-001 Parameter: WIDTH, default 128, width in bits of the packed stage payload (pc, control, rdat2, alu_out, pc_plus_imm, branch fields).
REQ-002 Parameter: CNT_W, default 16, width of the stall counter.
REQ-003 Port: CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: nRST  in  1  asynchronous active-low reset.
REQ-005 Port: flush  in  1  discard all held entries (branch mispredict / trap).
REQ-006 Port: in_valid  in  1  upstream (execute) entry valid.
REQ-007 Port: in_ready  out  1  stage accepts an entry this cycle.
REQ-008 Port: in_data  in  WIDTH  upstream payload.
REQ-009 Port: out_valid  out  1  downstream (memory) entry valid.
REQ-010 Port: out_ready  in  1  downstream consumes the entry this cycle.
REQ-011 Port: out_data  out  WIDTH  payload presented to memory stage.
REQ-012 Port: occupancy  out  2  number of entries held (0..2).
REQ-013 Port: stat_clr  in  1  synchronous clear of stall_cnt.
REQ-014 Port: stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-015 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; both evaluated in the same cycle.
REQ-016 States: EMPTY (0 entries), ONE (main register full), TWO (main and skid registers full); out_valid = (state != EMPTY); out_data = main register; occupancy = 0/1/2 per state.
REQ-017 EMPTY: in_fire -> ONE, main <= in_data; no in_fire -> EMPTY.
REQ-018 ONE: in_fire & !out_fire -> TWO, skid <= in_data; !in_fire & out_fire -> EMPTY; in_fire & out_fire -> ONE, main <= in_data; neither -> ONE.
REQ-019 TWO: out_fire -> ONE, main <= skid; else hold; in_ready = 0 so no input is taken.
REQ-020 in_ready is a registered signal equal to (next state != TWO); no combinational path from out_ready to in_ready.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL not change.
REQ-022 Latency: entry accepted at edge N is on out_data/out_valid after edge N when stage was EMPTY, or when ONE with simultaneous out_fire.
REQ-023 Order preserved: entries leave in acceptance order; no entry duplicated or dropped except by flush.
REQ-024 flush=1 has priority: next state EMPTY, in_ready <= 1, any in_fire or out_fire in that cycle has no effect on stored data; payload registers need not be cleared.
REQ-025 stall_cnt increments by 1 each cycle out_valid & !out_ready, saturating at 2^CNT_W-1; stat_clr forces 0 next edge with priority over increment; flush does not affect it.

Reset
REQ-026 nRST=0 asynchronously forces state EMPTY, out_valid=0, in_ready=1, occupancy=0, stall_cnt=0, main and skid registers 0.
REQ-027 Reset asserted mid-operation discards all held entries; first edge after release behaves as from EMPTY.

Configuration
REQ-028 Macro EXMEM_SKID_STAGE_SKID_EN: defined -> two-entry skid behaviour of REQ-016..REQ-020.
REQ-029 Without EXMEM_SKID_STAGE_SKID_EN: skid register and TWO state removed; in_ready = !out_valid | out_ready (combinational); occupancy max 1; all other requirements unchanged.

Verification
REQ-030 Reset, then in_valid=1, in_data=0xA5 for one cycle, out_ready=1 -> out_valid=1, out_data=0xA5 next cycle, occupancy=1, then 0.
REQ-031 SKID_EN: out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0; raise out_ready -> out 0x11 then 0x22, in_ready=1 one cycle after first out_fire.
REQ-032 Continuous in_valid and out_ready=1, push 0..99 -> 100 outputs in order, one per cycle, occupancy never 2.
REQ-033 occupancy=2 and flush=1 with in_valid=1, in_data=0x33 -> next cycle out_valid=0, occupancy=0, 0x33 never appears.
REQ-034 CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15; stat_clr=1 -> 0 next cycle.
REQ-035 Assert nRST low mid-cycle with occupancy=2 -> outputs reach reset values before next edge.
